// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES equal chunks,
// one register stage per chunk, with valid/ready flow control and bubble collapse.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned CW = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: STAGES must divide WIDTH exactly");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [STAGES:0]  ready;

    assign b_eff         = sub ? ~b : b;
    assign cin_eff       = c_in ^ sub;
    assign ready[STAGES] = out_ready;
    assign in_ready      = ready[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic                  v;
        logic                  cy;
        logic [CW*(i+1)-1:0]   res;
        logic [CW*(i+1)-1:0]   res_d;
        logic [CW-1:0]         a_ch;
        logic [CW-1:0]         b_ch;
        logic                  ci;
        logic                  load;
        logic [CW:0]           sum;

        // A stage is free when empty or when its content leaves this cycle
        assign ready[i] = !v || ready[i+1];
        assign sum      = {1'b0, a_ch} + {1'b0, b_ch} + {{CW{1'b0}}, ci};

        if (i == 0) begin : g_src
            assign a_ch  = a[CW-1:0];
            assign b_ch  = b_eff[CW-1:0];
            assign ci    = cin_eff;
            assign load  = in_valid && ready[0];
            assign res_d = sum[CW-1:0];
        end else begin : g_src
            assign a_ch  = g_stage[i-1].g_rem.a_rem[CW-1:0];
            assign b_ch  = g_stage[i-1].g_rem.b_rem[CW-1:0];
            assign ci    = g_stage[i-1].cy;
            assign load  = g_stage[i-1].v && ready[i];
            assign res_d = {sum[CW-1:0], g_stage[i-1].res};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v   <= 1'b0;
                cy  <= 1'b0;
                res <= '0;
            end else if (load) begin
                v   <= 1'b1;
                cy  <= sum[CW];
                res <= res_d;
            end else if (ready[i+1]) begin
                v   <= 1'b0;
            end
        end

        // Operand bits still waiting for the downstream chunks
        if (i < STAGES - 1) begin : g_rem
            localparam int unsigned RW = WIDTH - CW * (i + 1);
            logic [RW-1:0] a_rem;
            logic [RW-1:0] b_rem;
            logic [RW-1:0] a_rem_d;
            logic [RW-1:0] b_rem_d;

            if (i == 0) begin : g_first
                assign a_rem_d = a[WIDTH-1:CW];
                assign b_rem_d = b_eff[WIDTH-1:CW];
            end else begin : g_rest
                assign a_rem_d = g_stage[i-1].g_rem.a_rem[RW+CW-1:CW];
                assign b_rem_d = g_stage[i-1].g_rem.b_rem[RW+CW-1:CW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem <= '0;
                    b_rem <= '0;
                end else if (load) begin
                    a_rem <= a_rem_d;
                    b_rem <= b_rem_d;
                end
            end
        end

        // The top chunk carries the sign bits, so overflow is resolved here
        if (i == STAGES - 1) begin : g_last
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (load) begin
                    ovf_q <= (a_ch[CW-1] == b_ch[CW-1]) && (sum[CW-1] != a_ch[CW-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v;
    assign s         = g_stage[STAGES-1].res;
    assign c_out     = g_stage[STAGES-1].cy;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 16/4 main instance plus 4/2 and 4/1 instances
// swept exhaustively.
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, s;
    logic        c_in, sub, c_out, ovf;

    logic [3:0]  a4, b4, s2, s1;
    logic        ci4, sub4, iv4, or4;
    logic        ir2, ov2, co2, of2;
    logic        ir1, ov1, co1, of1;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp16[$];
    int          occ = 0;
    logic        hold = 1'b0;
    logic [18:0] held = '0;
    logic        saw_full = 1'b0;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf));

    pipelined_adder #(.WIDTH(4), .STAGES(2)) dut_w4s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir2),
        .a(a4), .b(b4), .c_in(ci4), .sub(sub4), .out_valid(ov2),
        .out_ready(or4), .s(s2), .c_out(co2), .ovf(of2));

    pipelined_adder #(.WIDTH(4), .STAGES(1)) dut_w4s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir1),
        .a(a4), .b(b4), .c_in(ci4), .sub(sub4), .out_valid(ov1),
        .out_ready(or4), .s(s1), .c_out(co1), .ovf(of1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flat reference: returns {ovf, c_out, s}
    function automatic logic [17:0] m16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
        logic [15:0] be;
        logic [16:0] t;
        be = sb ? ~y : y;
        t  = {1'b0, x} + {1'b0, be} + 17'(ci ^ sb);
        return {(x[15] == be[15]) && (t[15] != x[15]), t[16], t[15:0]};
    endfunction

    // Vector packs {sub, c_in, a, b}; returns {ovf, c_out, s}
    function automatic logic [5:0] m4(input logic [9:0] vec);
        logic [3:0] x, be;
        logic [4:0] t;
        x  = vec[7:4];
        be = vec[9] ? ~vec[3:0] : vec[3:0];
        t  = {1'b0, x} + {1'b0, be} + 5'(vec[8] ^ vec[9]);
        return {(x[3] == be[3]) && (t[3] != x[3]), t[4], t[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the main instance with scoreboard, in_ready model and stall-hold check
    task automatic cycle16();
        logic acc, del;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!(occ == 4 && !out_ready)));
        if (!in_ready) saw_full = 1'b1;
        if (hold) chk("stall_hold", 32'({out_valid, ovf, c_out, s}), 32'(held));
        hold = out_valid && !out_ready;
        held = {out_valid, ovf, c_out, s};
        acc  = in_valid && in_ready;
        del  = out_valid && out_ready;
        if (del) begin
            chk("out_expected", 32'(exp16.size() != 0), 32'(1));
            if (exp16.size() != 0) chk("result", 32'({ovf, c_out, s}), 32'(exp16.pop_front()));
        end
        if (acc) exp16.push_back(m16(a, b, c_in, sub));
        occ = occ + int'(acc) - int'(del);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while (exp16.size() != 0 && guard < 40) begin
            cycle16();
            guard++;
        end
        chk("drain_empty", 32'(exp16.size()), 32'(0));
    endtask

    task automatic rand_op();
        a    = 16'($urandom);
        b    = 16'($urandom);
        c_in = 1'($urandom);
        sub  = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        a4 = '0; b4 = '0; ci4 = 1'b0; sub4 = 1'b0; iv4 = 1'b0; or4 = 1'b1;

        // Reset state, while held and after release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_s", 32'(s), 32'(0));
        chk("rst_c_out", 32'(c_out), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_in_ready_w4s2", 32'(ir2), 32'(1));
        chk("rst_out_valid_w4s1", 32'(ov1), 32'(0));
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rel_in_ready", 32'(in_ready), 32'(1));

        // Carry ripples through every chunk
        a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_lat1", 32'(out_valid), 32'(0));
        step();
        chk("t1_lat2", 32'(out_valid), 32'(0));
        step();
        chk("t1_lat3", 32'(out_valid), 32'(0));
        step();
        chk("t1_valid", 32'(out_valid), 32'(1));
        chk("t1_result", 32'({ovf, c_out, s}), 32'({1'b0, 1'b1, 16'h0000}));
        step();
        chk("t1_gone", 32'(out_valid), 32'(0));

        // Overflow / subtract cases, back to back
        a = 16'h7FFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        step();
        a = 16'h0005; b = 16'h0007; sub = 1'b1;
        step();
        a = 16'h8000; b = 16'h0001; sub = 1'b1;
        step();
        in_valid = 1'b0; sub = 1'b0;
        step();
        chk("t2_add_ovf", 32'({out_valid, ovf, c_out, s}), 32'({1'b1, 1'b1, 1'b0, 16'h8000}));
        step();
        chk("t2_sub_neg", 32'({out_valid, ovf, c_out, s}), 32'({1'b1, 1'b0, 1'b0, 16'hFFFE}));
        step();
        chk("t2_sub_ovf", 32'({out_valid, ovf, c_out, s}), 32'({1'b1, 1'b1, 1'b1, 16'h7FFF}));
        step();
        chk("t2_gone", 32'(out_valid), 32'(0));

        // Ten back-to-back ops: latency 4 then one result per cycle
        for (int n = 0; n < 16; n++) begin
            chk("t3_out_valid", 32'(out_valid), 32'(n >= 4 && n <= 13));
            in_valid = (n < 10);
            rand_op();
            cycle16();
        end
        chk("t3_all_out", 32'(exp16.size()), 32'(0));

        // Six-cycle output stall mid-stream
        saw_full = 1'b0;
        for (int n = 0; n < 14; n++) begin
            in_valid  = 1'b1;
            out_ready = !(n >= 2 && n < 8);
            rand_op();
            cycle16();
        end
        drain();
        chk("t4_full_seen", 32'(saw_full), 32'(1));

        // Random valid/ready traffic
        for (int n = 0; n < 1000; n++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_op();
            cycle16();
        end
        drain();

        // Asynchronous reset with three ops in flight
        out_ready = 1'b0; in_valid = 1'b1; c_in = 1'b0; sub = 1'b0;
        a = 16'h1234; b = 16'h1111;
        cycle16();
        a = 16'h2222; b = 16'h0101;
        cycle16();
        a = 16'h4000; b = 16'h0003;
        cycle16();
        in_valid = 1'b0;
        cycle16();
        cycle16();
        chk("t5_pre_valid", 32'(out_valid), 32'(1));
        chk("t5_pre_s", 32'(s), 32'(16'h2345));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'(0));
        chk("t5_rst_s", 32'({ovf, c_out, s}), 32'(0));
        chk("t5_rst_in_ready", 32'(in_ready), 32'(1));
        exp16.delete();
        occ = 0; hold = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk("t5_idle", 32'(out_valid), 32'(0));
            cycle16();
        end
        a = 16'h0F0F; b = 16'h00F1; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
        cycle16();
        in_valid = 1'b0;
        for (int n = 1; n < 4; n++) begin
            chk("t5_new_lat", 32'(out_valid), 32'(0));
            cycle16();
        end
        chk("t5_new_valid", 32'(out_valid), 32'(1));
        chk("t5_new_s", 32'({ovf, c_out, s}), 32'({1'b0, 1'b0, 16'h1001}));
        drain();

        // Exhaustive 4-bit sweep: latency 2 (two stages) and 1 (one stage)
        for (int m = 0; m <= 1025; m++) begin
            iv4 = (m < 1024);
            {sub4, ci4, a4, b4} = 10'(m);
            @(negedge clk);
            chk("w4s1_in_ready", 32'(ir1), 32'(1));
            chk("w4s2_in_ready", 32'(ir2), 32'(1));
            chk("w4s1_valid", 32'(ov1), 32'(m >= 1 && m <= 1024));
            chk("w4s2_valid", 32'(ov2), 32'(m >= 2 && m <= 1025));
            if (m >= 1 && m <= 1024) chk("w4s1_result", 32'({of1, co1, s1}), 32'(m4(10'(m - 1))));
            if (m >= 2) chk("w4s2_result", 32'({of2, co2, s2}), 32'(m4(10'(m - 2))));
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
